// File: rtl/conv_pool_engine.sv
// conv_pool_engine: 3x3 zero-padded stride-1 convolution with per-kernel bias and ReLU over a
// 2^IMG_LOG2 square image, plus an optional 2x2 max-pool and interleaved flatten pass.
module conv_pool_engine #(
  parameter int IMG_LOG2 = 6,
  parameter int NUM_KER  = 2,
  parameter int DATA_W   = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  output logic                    busy,
  input  logic                    pool_en,
  input  logic                    kwr,
  input  logic [5:0]              kaddr,
  input  logic [DATA_W-1:0]       kdata,
  output logic [2*IMG_LOG2-1:0]   iaddr,
  input  logic [DATA_W-1:0]       idata,
  output logic                    cwr,
  output logic [2*IMG_LOG2-1:0]   caddr_wr,
  output logic [DATA_W-1:0]       cdata_wr,
  output logic                    crd,
  output logic [2*IMG_LOG2-1:0]   caddr_rd,
  input  logic [DATA_W-1:0]       cdata_rd,
  output logic [2:0]              csel
);
  localparam int IL = IMG_LOG2;
  localparam int AW = 2 * IMG_LOG2;
  localparam int KW = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NUM_KER - 1);
  localparam logic [KW-1:0] KONE  = KW'(1);
  localparam logic [1:0]    KMAX  = 2'(NUM_KER - 1);
  localparam logic [AW-1:0] KMUL  = AW'(NUM_KER);
  localparam logic [IL-1:0] ONE   = IL'(1);
  localparam logic [IL-1:0] TWO   = IL'(2);

  typedef enum logic [2:0] {IDLE, CONV, BIAS, WR0, POOL_RD, WR1, FLAT, DONE} state_t;
  state_t state_q, state_d;

  logic [IL-1:0]            row_q, row_d, col_q, col_d;
  logic [KW-1:0]            k_q, k_d;
  logic [3:0]               t_q, t_d;
  logic [2:0]               p_q, p_d;
  logic signed [43:0]       acc_q, acc_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     pool_q, pool_d;
  logic [DATA_W-1:0]        coef_q [NUM_KER][10];
  logic [DATA_W-1:0]        coef_d [NUM_KER][10];

  // Tap index t maps row-major onto offsets 0/1/2 meaning -1/0/+1.
  function automatic logic [1:0] tap_dy(input logic [3:0] t);
    case (t)
      4'd0, 4'd1, 4'd2: tap_dy = 2'd0;
      4'd3, 4'd4, 4'd5: tap_dy = 2'd1;
      default:          tap_dy = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_dx(input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: tap_dx = 2'd0;
      4'd1, 4'd4, 4'd7: tap_dx = 2'd1;
      default:          tap_dx = 2'd2;
    endcase
  endfunction

  function automatic logic [IL-1:0] coord(input logic [IL-1:0] b, input logic [1:0] d);
    case (d)
      2'd0:    coord = b - ONE;
      2'd1:    coord = b;
      default: coord = b + ONE;
    endcase
  endfunction

  function automatic logic in_img(input logic [IL-1:0] b, input logic [1:0] d);
    in_img = !((d == 2'd0 && b == '0) || (d == 2'd2 && b == '1));
  endfunction

  // idata arriving now belongs to the tap issued last cycle.
  logic [3:0]               tp;
  logic                     tap_ok;
  logic [DATA_W-1:0]        cf, bias;
  logic signed [2*DATA_W-1:0] mul;
  logic [43:0]              prod_ext, bias_ext;
  logic [DATA_W-1:0]        relu_val;
  logic [AW-1:0]            widx;
  logic                     wr_ok;

  assign tp       = t_q - 4'd1;
  assign tap_ok   = in_img(row_q, tap_dy(tp)) && in_img(col_q, tap_dx(tp));
  assign cf       = coef_q[k_q][tp];
  assign bias     = coef_q[k_q][4'd9];
  assign mul      = $signed(idata) * $signed(cf);
  assign prod_ext = tap_ok ? {{(44-2*DATA_W){mul[2*DATA_W-1]}}, mul} : '0;
  assign bias_ext = {{(28-DATA_W){bias[DATA_W-1]}}, bias, 16'b0};
  assign relu_val = acc_q[43] ? '0 : (acc_q[DATA_W+15:16] + DATA_W'(acc_q[15]));
  assign widx     = AW'({row_q[IL-1:1], col_q[IL-1:1]});
  assign wr_ok    = kwr && (state_q == IDLE) && (kaddr[5:4] <= KMAX) && (kaddr[3:0] <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      k_q    <= '0;
      t_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      max_q  <= '0;
      pool_q <= 1'b0;
      for (int i = 0; i < NUM_KER; i++)
        for (int j = 0; j < 10; j++)
          coef_q[i][j] <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      k_q    <= k_d;
      t_q    <= t_d;
      p_q    <= p_d;
      acc_q  <= acc_d;
      max_q  <= max_d;
      pool_q <= pool_d;
      coef_q <= coef_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ready) state_d = CONV;
      CONV:    if (t_q == 4'd9) state_d = BIAS;
      BIAS:    state_d = WR0;
      WR0:     if (k_q == KLAST && col_q == '1 && row_q == '1)
                 state_d = pool_q ? POOL_RD : DONE;
               else
                 state_d = CONV;
      POOL_RD: if (p_q == 3'd4) state_d = WR1;
      WR1:     state_d = FLAT;
      FLAT:    if (k_q == KLAST && col_q[IL-1:1] == '1 && row_q[IL-1:1] == '1)
                 state_d = DONE;
               else
                 state_d = POOL_RD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    k_d    = k_q;
    t_d    = t_q;
    p_d    = p_q;
    acc_d  = acc_q;
    max_d  = max_q;
    pool_d = pool_q;
    coef_d = coef_q;
    if (wr_ok) coef_d[kaddr[4 +: KW]][kaddr[3:0]] = kdata;
    case (state_q)
      IDLE: if (ready) begin
        row_d  = '0;
        col_d  = '0;
        k_d    = '0;
        t_d    = '0;
        p_d    = '0;
        acc_d  = '0;
        pool_d = pool_en;
      end
      CONV: begin
        t_d = t_q + 4'd1;
        if (t_q != 4'd0) acc_d = acc_q + prod_ext;
      end
      BIAS: acc_d = acc_q + bias_ext;
      // Counters wrap naturally at N, which also leaves (0,0,0) ready for the pool pass.
      WR0: begin
        acc_d = '0;
        t_d   = '0;
        if (k_q != KLAST) k_d = k_q + KONE;
        else begin
          k_d   = '0;
          col_d = col_q + ONE;
          if (col_q == '1) row_d = row_q + ONE;
        end
      end
      POOL_RD: begin
        p_d = (p_q == 3'd4) ? 3'd0 : p_q + 3'd1;
        if (p_q == 3'd1) max_d = cdata_rd;
        else if (p_q >= 3'd2 && $signed(cdata_rd) > max_q) max_d = cdata_rd;
      end
      FLAT: begin
        if (k_q != KLAST) k_d = k_q + KONE;
        else begin
          k_d   = '0;
          col_d = col_q + TWO;
          if (col_q[IL-1:1] == '1) row_d = row_q + TWO;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    iaddr    = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    csel     = 3'd0;
    case (state_q)
      CONV: if (t_q <= 4'd8)
        iaddr = {coord(row_q, tap_dy(t_q)), coord(col_q, tap_dx(t_q))};
      WR0: begin
        cwr      = 1'b1;
        csel     = 3'(k_q) + 3'd1;
        caddr_wr = {row_q, col_q};
        cdata_wr = relu_val;
      end
      POOL_RD: if (p_q <= 3'd3) begin
        crd      = 1'b1;
        csel     = 3'(k_q) + 3'd1;
        caddr_rd = {row_q + IL'(p_q[1]), col_q + IL'(p_q[0])};
      end
      WR1: begin
        cwr      = 1'b1;
        csel     = 3'(k_q) + 3'd4;
        caddr_wr = widx;
        cdata_wr = max_q;
      end
      FLAT: begin
        cwr      = 1'b1;
        csel     = 3'd7;
        caddr_wr = widx * KMUL + AW'(k_q);
        cdata_wr = max_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine: image ROM and banked layer memory models, with every result
// compared against a direct arithmetic model of the convolution, ReLU, pooling and flatten.
module tb_conv_pool_engine;
  localparam int IL = 3;
  localparam int N  = 1 << IL;
  localparam int K  = 3;
  localparam int DW = 20;
  localparam int AW = 2 * IL;

  logic          clk = 1'b0, reset = 1'b1, ready = 1'b0, pool_en = 1'b0, kwr = 1'b0;
  logic [5:0]    kaddr = '0;
  logic [DW-1:0] kdata = '0, idata = '0, cdata_rd = '0;
  logic          busy, cwr, crd;
  logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] img [N*N];
  logic [DW-1:0] cf [K][10];
  logic [DW-1:0] bank [8][N*N];
  int            wstamp [8][N*N];
  int            run_id = 0, wcnt = 0, nvec = 0, nerr = 0;

  conv_pool_engine #(.IMG_LOG2(IL), .NUM_KER(K), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .pool_en(pool_en),
    .kwr(kwr), .kaddr(kaddr), .kdata(kdata), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) idata <= img[iaddr];
  always @(posedge clk) if (crd) cdata_rd <= bank[csel][caddr_rd];
  always @(posedge clk) if (cwr) begin
    bank[csel][caddr_wr]   <= cdata_wr;
    wstamp[csel][caddr_wr] <= run_id;
    wcnt                   <= wcnt + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Bank word written during the current run, or -1 if it was not.
  function automatic longint rd(input int b, input int a);
    if (wstamp[b][a] == run_id) return longint'(bank[b][a]);
    return -1;
  endfunction

  function automatic logic [DW-1:0] exp_l0(input int k, input int r, input int c);
    longint acc;
    acc = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (r + dy >= 0 && r + dy < N && c + dx >= 0 && c + dx < N)
          acc += sx(img[(r + dy) * N + c + dx]) * sx(cf[k][(dy + 1) * 3 + dx + 1]);
    acc += sx(cf[k][9]) * 65536;
    if (acc < 0) return '0;
    return DW'((acc >> 16) + ((acc >> 15) & 1));
  endfunction

  function automatic logic [DW-1:0] exp_pool(input int k, input int w);
    int r, c;
    longint m, v;
    r = (w / (N / 2)) * 2;
    c = (w % (N / 2)) * 2;
    m = sx(exp_l0(k, r, c));
    for (int i = 1; i < 4; i++) begin
      v = sx(exp_l0(k, r + i / 2, c + i % 2));
      if (v > m) m = v;
    end
    return DW'(m);
  endfunction

  function automatic logic [DW-1:0] sm();
    return DW'(int'($urandom_range(0, 262143)) - 131072);
  endfunction

  task automatic kw(input int k, input int t, input logic [DW-1:0] v);
    @(negedge clk);
    kwr = 1'b1; kaddr = {2'(k), 4'(t)}; kdata = v; cf[k][t] = v;
    @(negedge clk);
    kwr = 1'b0;
  endtask

  task automatic set_kernel(input int k, input logic [DW-1:0] tap, input logic [DW-1:0] ctr,
                            input logic [DW-1:0] b);
    for (int t = 0; t < 9; t++) kw(k, t, (t == 4) ? ctr : tap);
    kw(k, 9, b);
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < N * N; i++) img[i] = v;
  endtask

  task automatic run(input bit pool, input bit disturb, input bit startwr, input logic [DW-1:0] swv,
                     output int cyc, output int nw);
    int w0;
    run_id++;
    @(negedge clk);
    ready = 1'b1; pool_en = pool;
    if (startwr) begin kwr = 1'b1; kaddr = 6'h04; kdata = swv; cf[0][4] = swv; end
    w0 = wcnt;
    @(negedge clk);
    ready = 1'b0; pool_en = 1'b0; kwr = 1'b0; cyc = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      cyc++;
      if (disturb && (cyc == 300 || cyc == 2500)) begin
        ready = 1'b1; kwr = 1'b1; kaddr = 6'h04; kdata = DW'($urandom);
      end else begin
        ready = 1'b0; kwr = 1'b0;
      end
      @(negedge clk);
    end
    ready = 1'b0; kwr = 1'b0;
    if (cyc >= 20000) chk("run_timeout", cyc, 0);
    nw = wcnt - w0;
  endtask

  task automatic check_run(input bit pool, input int cyc, input int nw);
    logic [DW-1:0] e;
    chk("busy_cycles", cyc, 12 * N * N * K + (pool ? 7 * (N / 2) * (N / 2) * K : 0) + 1);
    chk("write_count", nw, N * N * K + (pool ? 2 * (N / 2) * (N / 2) * K : 0));
    for (int k = 0; k < K; k++)
      for (int p = 0; p < N * N; p++)
        chk($sformatf("L0 run%0d k%0d px%0d", run_id, k, p), rd(k + 1, p), exp_l0(k, p / N, p % N));
    if (pool)
      for (int k = 0; k < K; k++)
        for (int w = 0; w < (N / 2) * (N / 2); w++) begin
          e = exp_pool(k, w);
          chk($sformatf("L1 run%0d k%0d w%0d", run_id, k, w), rd(k + 4, w), e);
          chk($sformatf("FLAT run%0d k%0d w%0d", run_id, k, w), rd(7, w * K + k), e);
        end
  endtask

  initial begin
    int cyc, nw, w0;
    bit pl;
    for (int i = 0; i < N * N; i++) img[i] = '0;
    for (int k = 0; k < K; k++) for (int t = 0; t < 10; t++) cf[k][t] = '0;

    #12;
    chk("rst_busy", busy, 0);     chk("rst_cwr", cwr, 0);
    chk("rst_crd", crd, 0);       chk("rst_csel", csel, 0);
    chk("rst_iaddr", iaddr, 0);   chk("rst_caddr_wr", caddr_wr, 0);
    chk("rst_cdata_wr", cdata_wr, 0); chk("rst_caddr_rd", caddr_rd, 0);
    @(negedge clk);
    reset = 1'b0;

    // Coefficients come out of reset as zero.
    for (int i = 0; i < N * N; i++) img[i] = sm();
    run(1'b1, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b1, cyc, nw);

    // All-ones kernels on an all-ones image.
    for (int k = 0; k < K; k++) set_kernel(k, DW'('h10000), DW'('h10000), '0);
    fill(DW'('h10000));
    run(1'b0, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b0, cyc, nw);
    chk("ones_corner00", rd(1, 0), 'h40000);
    chk("ones_corner77", rd(1, N * N - 1), 'h40000);
    chk("ones_edge", rd(1, 1), 'h60000);
    chk("ones_interior", rd(1, N + 1), 'h90000);

    // Rounding at exactly one half LSB and just below.
    for (int k = 0; k < K; k++) set_kernel(k, '0, DW'(1), '0);
    fill(DW'('h08000));
    run(1'b0, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b0, cyc, nw);
    chk("round_half_up", rd(1, N + 1), 1);
    fill(DW'('h07FFF));
    run(1'b0, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b0, cyc, nw);
    chk("round_below_half", rd(1, N + 1), 0);

    // Negative bias drives ReLU to zero.
    kw(0, 9, DW'('hF0000));
    fill(DW'('h10000));
    run(1'b0, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b0, cyc, nw);
    chk("relu_interior", rd(1, N + 1), 0);
    chk("relu_corner", rd(1, 0), 0);

    // Ramp image, scaled centre taps, pooling on.
    for (int k = 0; k < K; k++) set_kernel(k, '0, DW'((k + 1) * 'h10000), '0);
    for (int i = 0; i < N * N; i++) img[i] = DW'(i * 'h800);
    run(1'b1, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b1, cyc, nw);
    for (int k = 0; k < K; k++) begin
      chk($sformatf("ramp_l1_k%0d", k), rd(4 + k, 0), (N + 1) * 'h800 * (k + 1));
      chk($sformatf("ramp_flat_k%0d", k), rd(7, k), (N + 1) * 'h800 * (k + 1));
    end

    // Only the far corner is lit: the wrapped tap address must not leak into (0,0).
    for (int k = 0; k < K; k++) set_kernel(k, DW'('h10000), DW'('h10000), '0);
    fill('0);
    img[N * N - 1] = DW'('h10000);
    run(1'b0, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b0, cyc, nw);
    chk("wrap_px00", rd(1, 0), 0);
    chk("wrap_px77", rd(1, N * N - 1), 'h10000);

    // Random coefficients and images; includes a kwr with the accepted ready and
    // ignored kwr/ready while busy.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < K; k++) for (int t = 0; t < 10; t++)
        kw(k, t, (n == 1) ? DW'($urandom) : sm());
      for (int i = 0; i < N * N; i++) img[i] = (n == 1) ? DW'($urandom) : sm();
      pl = (n != 1);
      run(pl, n == 2, n == 1, sm(), cyc, nw); check_run(pl, cyc, nw);
    end
    run(1'b1, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b1, cyc, nw);

    // Reset in the middle of a run, landing on a write cycle.
    run_id++;
    @(negedge clk);
    ready = 1'b1; pool_en = 1'b1;
    @(negedge clk);
    ready = 1'b0; pool_en = 1'b0;
    repeat (503) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_cwr", cwr, 1);
    w0 = wcnt;
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_cwr", cwr, 0);
    chk("mid_reset_crd", crd, 0);
    chk("mid_reset_csel", csel, 0);
    repeat (3) @(negedge clk);
    chk("mid_reset_no_write", wcnt, w0);
    reset = 1'b0;
    for (int k = 0; k < K; k++) for (int t = 0; t < 10; t++) cf[k][t] = '0;
    run(1'b1, 1'b0, 1'b0, '0, cyc, nw); check_run(1'b1, cyc, nw);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv_pool_engine.md
# conv_pool_engine

Parametrised successor to the fixed 64×64 convolution layer. It runs a 3×3, zero-padded, stride-1 convolution of a 2^IMG_LOG2-square image with NUM_KER run-time-loadable kernels, each with its own bias, followed by ReLU. An optional 2×2/stride-2 max-pool and interleaved flatten stage follows when `pool_en` is set. It sits between the testbench/host image ROM and the shared layer memory, which is selected by `csel`.

## Interface
Parameters:
- IMG_LOG2, 6: image side N = 2^IMG_LOG2; legal range 2..6.
- NUM_KER, 2: number of kernels; legal range 1..3.
- DATA_W, 20: pixel, coefficient and result width; signed fixed-point, 4 integer bits and 16 fractional bits.

Ports:
- clk  in  1  clock; reset is asynchronous, active-high, named `reset` (already decided).
- reset  in  1  asynchronous active-high reset.
- ready  in  1  start request; sampled only in IDLE.
- busy  out  1  high from the cycle after `ready` is accepted until the end of DONE.
- pool_en  in  1  enables the pool/flatten stage; latched when `ready` is accepted.
- kwr  in  1  coefficient write strobe; honoured only while busy=0.
- kaddr  in  6  coefficient address {kernel[1:0], tap[3:0]}; taps 0..8 are row-major (tap 0 = (-1,-1)); tap 9 is the bias.
- kdata  in  DATA_W  coefficient value.
- iaddr  out  2*IMG_LOG2  image address {row, col}.
- idata  in  DATA_W  image data; valid one cycle after `iaddr`.
- cwr, caddr_wr, cdata_wr  out  1/2*IMG_LOG2/DATA_W  layer memory write port.
- crd, caddr_rd  out  1/2*IMG_LOG2  layer memory read port.
- cdata_rd  in  DATA_W  read data; valid one cycle after `caddr_rd`.
- csel  out  3  bank select: L0 kernel k = k+1; L1 kernel k = k+4; flatten = 7.

## Operation
- FSM states: IDLE, CONV, BIAS, WR0, POOL_RD, WR1, FLAT, DONE.
- IDLE → CONV on `ready`. At the same edge, row, col, k and the accumulator clear to 0.
- CONV uses tap counter t = 0..9:
  - For t ≤ 8: drive `iaddr` = {row+dy, col+dx} of tap t.
  - For t ≥ 1: acc += idata × coef[k][t-1].
  - A tap whose coordinate falls outside 0..N-1 contributes 0. The address is still issued, with modulo-N wrap.
- At t = 9 → BIAS: acc += bias[k] << 16.
- acc is 44-bit signed. Each product is 40-bit signed and sign-extended.
- WR0: cwr=1, csel=k+1, caddr_wr={row,col}.
  - cdata_wr = 0 if acc < 0.
  - Otherwise cdata_wr = acc[35:16] + acc[15] (round half up, truncate to DATA_W).
- After WR0:
  - If k < NUM_KER-1: k++, back to CONV.
  - Else k=0 and the pixel advances col-major-inner (col++, wrap to 0 with row++).
  - After pixel (N-1,N-1): go to POOL_RD if pool_en, else DONE.
- POOL_RD (per window (row,col) with even coordinates, per kernel k), counter p = 0..4:
  - crd=1 and csel=k+1 for p ≤ 3.
  - caddr_rd order: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  - max is loaded at p=1 and updated by signed compare at p=2..4.
- WR1: csel=k+4, caddr_wr={row>>1, col>>1}, cdata_wr=max.
- FLAT: csel=7, caddr_wr = ({row>>1,col>>1})·NUM_KER + k, cdata_wr=max.
- After FLAT, k iterates first, then col += 2, then row += 2. After window (N-2,N-2) with the last k → DONE.
- DONE lasts one cycle, then → IDLE. A new `ready` starts a full new run with the stored coefficients.
- `ready` and `kwr` while busy=1 are ignored. Coefficients persist across runs.

## Timing
- Reset values:
  - Outputs: busy=0, cwr=0, crd=0, csel=0, all addresses and data = 0.
  - All coefficients and biases are 0. FSM is in IDLE.
- Reset mid-run aborts immediately to these values. No partial write occurs after the reset edge.
- Per pixel per kernel: 12 cycles (CONV 10, BIAS 1, WR0 1).
- Per window per kernel: 7 cycles (POOL_RD 5, WR1 1, FLAT 1).
- Total busy cycles = 12·N²·K + (pool_en ? 7·(N/2)²·K : 0) + 1 (DONE).
- cwr is a single-cycle pulse in WR0/WR1/FLAT, and only there. crd is high only in POOL_RD with p ≤ 3.
- A `kwr` in the same cycle as an accepted `ready` is honoured, because busy is still 0.

## Test plan
- IMG_LOG2=3, NUM_KER=1, all taps 0x10000, bias 0, image all 0x10000, pool_en=0 → bank 1:
  - corners = 0x40000, edges = 0x60000, interior = 0x90000.
  - busy high for exactly 769 cycles.
- Rounding, with center tap 0x00001 and others 0:
  - pixel 0x08000 → output 0x00001.
  - pixel 0x07FFF → output 0x00000.
  - bias 0xF0000 (-1.0) on image 0x10000 → all outputs 0 (ReLU).
- NUM_KER=3, IMG_LOG2=2, ramp image (value = index·0x1000), kernel k = center tap (k+1)·0x10000, pool_en=1:
  - bank k+4 holds the window max·(k+1).
  - bank 7 address w·3+k holds the same value.
- Reset asserted at cycle 500 of a run → busy, cwr and crd drop the same cycle. Re-issue `ready` without reloading → every L0 write equals 0.
- `kwr` during busy (change center tap) → current and next run results are unchanged. `ready` pulse during busy → no restart; the total cycle count is unchanged.
- Border wrap: image has 0x10000 only at (N-1,N-1), all taps 0x10000 → pixel (0,0) output is 0, confirming no modulo-wrap contribution.
